// File: rtl/regfile_mp.sv
// Multi-port general register file: NRD combinational read ports with bypass from two
// write ports, optional hardwired zero entry, commit trace and a one-entry-per-cycle clear sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [1:0]            trace_we,
    output logic [2*ADDR_W-1:0]   trace_addr,
    output logic [2*DATA_W-1:0]   trace_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_n;
    logic [ADDR_W-1:0]   ptr_r;
    logic [ADDR_W-1:0]   ptr_n;
    logic                eff0_s;
    logic                eff1_s;
    logic                sweep_s;
    logic                clr_busy_r;
    logic                clr_done_r;
    logic [1:0]          trace_we_r;
    logic [2*ADDR_W-1:0] trace_addr_r;
    logic [2*DATA_W-1:0] trace_data_r;
    logic [DATA_W-1:0]   mem_s [DEPTH];

    assign sweep_s = (state_r == ST_CLEAR);

    // Write-effective qualification: ports are dead during the sweep and for the zero entry
    always_comb begin
        eff0_s = 1'b0;
        eff1_s = 1'b0;
        if (!sweep_s) begin
            eff0_s = we0 && !(HAS_ZERO && (wa0 == ZERO_ADDR));
            eff1_s = we1 && !(HAS_ZERO && (wa1 == ZERO_ADDR));
        end else begin
            eff0_s = 1'b0;
            eff1_s = 1'b0;
        end
    end

    // Sweep FSM next-state and pointer logic
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_start) begin
                    state_n = ST_CLEAR;
                    ptr_n   = ZERO_ADDR;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // ptr wraps to 0 on the same edge that leaves CLEAR
                ptr_n = ptr_r + PTR_ONE;
                if (ptr_r == LAST_ADDR) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                ptr_n   = ZERO_ADDR;
            end
        endcase
    end

    // FSM state, pointer and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ptr_r      <= ZERO_ADDR;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            ptr_r      <= ptr_n;
            clr_busy_r <= (state_n == ST_CLEAR);
            clr_done_r <= (state_n == ST_DONE);
        end
    end

    // One register per entry; port 1 has priority over port 0 on an address collision
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
        logic [DATA_W-1:0] ent_r;

        // Entry update: reset, sweep clear, then port writes
        always_ff @(posedge clk) begin
            if (reset) begin
                ent_r <= {DATA_W{1'b0}};
            end else if (sweep_s && (ptr_r == IDX)) begin
                ent_r <= {DATA_W{1'b0}};
            end else if (eff1_s && (wa1 == IDX)) begin
                ent_r <= wd1;
            end else if (eff0_s && (wa0 == IDX)) begin
                ent_r <= wd0;
            end
        end

        assign mem_s[i] = ent_r;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k_s;
        logic [DATA_W-1:0] rd_k_s;

        assign ra_k_s = ra[k*ADDR_W +: ADDR_W];

        // Read mux with write-through bypass
        always_comb begin
            rd_k_s = {DATA_W{1'b0}};
            if (HAS_ZERO && (ra_k_s == ZERO_ADDR)) begin
                rd_k_s = {DATA_W{1'b0}};
            end else if (eff1_s && (wa1 == ra_k_s)) begin
                rd_k_s = wd1;
            end else if (eff0_s && (wa0 == ra_k_s)) begin
                rd_k_s = wd0;
            end else begin
                rd_k_s = mem_s[ra_k_s];
            end
        end

        assign rd[k*DATA_W +: DATA_W] = rd_k_s;
    end

    // Commit trace: non-committed slots report zero address and data
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_we_r   <= 2'b00;
            trace_addr_r <= {(2*ADDR_W){1'b0}};
            trace_data_r <= {(2*DATA_W){1'b0}};
        end else begin
            trace_we_r   <= {eff1_s, eff0_s};
            trace_addr_r <= {(eff1_s ? wa1 : ZERO_ADDR), (eff0_s ? wa0 : ZERO_ADDR)};
            trace_data_r <= {(eff1_s ? wd1 : {DATA_W{1'b0}}), (eff0_s ? wd0 : {DATA_W{1'b0}})};
        end
    end

    assign clr_busy   = clr_busy_r;
    assign clr_done   = clr_done_r;
    assign trace_we   = trace_we_r;
    assign trace_addr = trace_addr_r;
    assign trace_data = trace_data_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 2-port/32-bit instance plus a 4-port/16-bit instance.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        clr_start, clr_busy, clr_done;
    logic [1:0]  trace_we;
    logic [9:0]  trace_addr;
    logic [63:0] trace_data;

    logic [19:0] ra4;
    logic [63:0] rd4;
    logic        we0_4, we1_4;
    logic [4:0]  wa0_4, wa1_4;
    logic [15:0] wd0_4, wd1_4;
    logic        clr_start_4, clr_busy_4, clr_done_4;
    logic [1:0]  trace_we_4;
    logic [9:0]  trace_addr_4;
    logic [31:0] trace_data_4;

    int vectors = 0;
    int miscompares = 0;
    int busy_cnt;
    int done_cnt;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .trace_we(trace_we), .trace_addr(trace_addr), .trace_data(trace_data)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(5), .NRD(4), .ZERO_REG(1)) dut4 (
        .clk(clk), .reset(reset), .ra(ra4), .rd(rd4),
        .we0(we0_4), .wa0(wa0_4), .wd0(wd0_4), .we1(we1_4), .wa1(wa1_4), .wd1(wd1_4),
        .clr_start(clr_start_4), .clr_busy(clr_busy_4), .clr_done(clr_done_4),
        .trace_we(trace_we_4), .trace_addr(trace_addr_4), .trace_data(trace_data_4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ra = 10'd0; clr_start = 1'b0;
        we0 = 1'b0; wa0 = 5'd0; wd0 = 32'd0; we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
        ra4 = 20'd0; clr_start_4 = 1'b0;
        we0_4 = 1'b0; wa0_4 = 5'd0; wd0_4 = 16'd0; we1_4 = 1'b0; wa1_4 = 5'd0; wd1_4 = 16'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", {63'd0, clr_busy}, 64'd0);
        chk("rst_done", {63'd0, clr_done}, 64'd0);
        chk("rst_twe", {62'd0, trace_we}, 64'd0);
        chk("rst_taddr", {54'd0, trace_addr}, 64'd0);
        chk("rst_tdata", trace_data, 64'd0);
        chk("rst_flags4", {62'd0, clr_busy_4, clr_done_4}, 64'd0);
        ra = {5'd9, 5'd5};
        #1;
        chk("rst_rd", rd, 64'd0);

        // single write with bypass, array and trace
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h12345678; ra = {5'd0, 5'd3};
        #1;
        chk("byp0", {32'd0, rd[31:0]}, 64'h12345678);
        tick();
        we0 = 1'b0;
        #1;
        chk("arr0", {32'd0, rd[31:0]}, 64'h12345678);
        chk("twe_a", {62'd0, trace_we}, 64'd1);
        chk("taddr_a", {54'd0, trace_addr}, 64'd3);
        chk("tdata_a", trace_data, 64'h12345678);
        tick();
        #1;
        chk("twe_idle", {62'd0, trace_we}, 64'd0);
        chk("tdata_idle", trace_data, 64'd0);

        // same-address collision: port 1 wins, both traced
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA0000;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555FFFF; ra = {5'd7, 5'd7};
        #1;
        chk("byp_pri", rd, {32'h5555FFFF, 32'h5555FFFF});
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("arr_pri", rd, {32'h5555FFFF, 32'h5555FFFF});
        chk("twe_pri", {62'd0, trace_we}, 64'd3);
        chk("taddr_pri", {54'd0, trace_addr}, {54'd0, 5'd7, 5'd7});
        chk("tdata_pri", trace_data, {32'h5555FFFF, 32'hAAAA0000});

        // distinct addresses on both ports
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h11110000;
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h22220000; ra = {5'd10, 5'd9};
        #1;
        chk("byp_two", rd, {32'h22220000, 32'h11110000});
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("arr_two", rd, {32'h22220000, 32'h11110000});

        // hardwired zero entry
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra = {5'd3, 5'd0};
        #1;
        chk("zero_byp", rd, {32'h12345678, 32'h0});
        tick();
        we0 = 1'b0;
        #1;
        chk("zero_arr", {32'd0, rd[31:0]}, 64'd0);
        chk("zero_twe", {62'd0, trace_we}, 64'd0);
        chk("zero_taddr", {54'd0, trace_addr}, 64'd0);

        // fill every entry with index+1
        for (int i = 0; i < 32; i++) begin
            we0 = 1'b1; wa0 = i[4:0]; wd0 = 32'(i + 1);
            tick();
        end
        we0 = 1'b0;
        ra = {5'd31, 5'd5};
        #1;
        chk("fill_hi", rd, {32'd32, 32'd6});
        ra = {5'd1, 5'd0};
        #1;
        chk("fill_lo", rd, {32'd2, 32'd0});

        // full clear sweep with dropped writes and an ignored restart in DONE
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 36; c++) begin
            #1;
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (c == 1) chk("busy_first", {63'd0, clr_busy}, 64'd1);
            if (c == 10) begin
                we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hDEAD;
                we1 = 1'b1; wa1 = 5'd20; wd1 = 32'hBEEF; ra = {5'd2, 5'd20};
                #1;
                chk("sweep_nobyp", rd, {32'd0, 32'd21});
            end
            if (c == 11) begin
                we0 = 1'b0; we1 = 1'b0;
                #1;
                chk("sweep_twe", {62'd0, trace_we}, 64'd0);
            end
            if (c == 32) chk("busy_last", {63'd0, clr_busy}, 64'd1);
            if (c == 33) begin
                chk("done_pulse", {62'd0, clr_busy, clr_done}, 64'd1);
                clr_start = 1'b1; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'd44;
            end
            if (c == 34) begin
                chk("done_ign", {62'd0, clr_busy, clr_done}, 64'd0);
                clr_start = 1'b0; we0 = 1'b0;
            end
            tick();
        end
        chk("busy_cnt", 64'(busy_cnt), 64'd32);
        chk("done_cnt", 64'(done_cnt), 64'd1);
        for (int i = 0; i < 32; i++) begin
            ra = {5'd0, i[4:0]};
            #1;
            chk("swept", {32'd0, rd[31:0]}, (i == 4) ? 64'd44 : 64'd0);
        end

        // reset in the 10th sweep cycle, together with writes and clr_start
        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h20;
        tick();
        we0 = 1'b0; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) begin
                reset = 1'b1; clr_start = 1'b1;
                we0 = 1'b1; wa0 = 5'd6; wd0 = 32'd66;
                we1 = 1'b1; wa1 = 5'd7; wd1 = 32'd77;
            end
            tick();
        end
        reset = 1'b0; clr_start = 1'b0; we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("abort_busy", {62'd0, clr_busy, clr_done}, 64'd0);
        chk("abort_twe", {62'd0, trace_we}, 64'd0);
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 34; c++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            tick();
        end
        chk("abort_quiet", 64'(busy_cnt + done_cnt), 64'd0);
        ra = {5'd6, 5'd20};
        #1;
        chk("abort_zero_a", rd, 64'd0);
        ra = {5'd7, 5'd31};
        #1;
        chk("abort_zero_b", rd, 64'd0);

        // a fresh sweep after the aborted one
        we0 = 1'b1; wa0 = 5'd31; wd0 = 32'h31;
        tick();
        we0 = 1'b0; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 36; c++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            tick();
        end
        chk("resweep_busy", 64'(busy_cnt), 64'd32);
        chk("resweep_done", 64'(done_cnt), 64'd1);
        ra = {5'd0, 5'd31};
        #1;
        chk("resweep_clr", {32'd0, rd[31:0]}, 64'd0);

        // four read ports, 16-bit data
        we0_4 = 1'b1; wa0_4 = 5'd2; wd0_4 = 16'h1234;
        tick();
        we0_4 = 1'b0;
        ra4 = {5'd0, 5'd1, 5'd2, 5'd1};
        we1_4 = 1'b1; wa1_4 = 5'd1; wd1_4 = 16'hBEEF;
        #1;
        chk("nrd4_byp", rd4, {16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF});
        tick();
        we1_4 = 1'b0;
        #1;
        chk("nrd4_arr", rd4, {16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF});
        chk("nrd4_twe", {62'd0, trace_we_4}, 64'd2);
        chk("nrd4_taddr", {54'd0, trace_addr_4}, {54'd0, 5'd1, 5'd0});
        chk("nrd4_tdata", {32'd0, trace_data_4}, {32'd0, 16'hBEEF, 16'h0000});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
